mips32_boot_loader: RTL and testbench
=====================================

Name: mips32_boot_loader

Overview:
- Byte-stream program loader that sits directly upstream of the mips32 core and its unified instruction/data memory.
- Receives a framed image over a valid/ready byte interface, assembles big-endian 32-bit words and writes them into memory.
- Verifies an XOR checksum over the frame.
- Holds the core halted until the load succeeds, then releases it with the start PC. Replaces hand-poking of memory, pc and halted.

Parameters:
ADDR_W, 10, memory word-address width (memory depth 2^ADDR_W words)
MAGIC, 8'hA5, frame start byte

Ports:
clk1  in  1  single clock, all state updates on its rising edge
rst  in  1  asynchronous, active-high reset
rx_data  in  8  incoming byte
rx_valid  in  1  rx_data valid this cycle
rx_ready  out  1  loader accepts a byte this cycle (transfer = rx_valid & rx_ready)
mem_we  out  1  one-cycle memory write strobe
mem_addr  out  ADDR_W  word address of the write
mem_wdata  out  32  word being written
core_hold  out  1  1 = core held halted with pc forced; 0 = core runs
pc_start  out  ADDR_W  PC to load into the core on release
boot_done  out  1  sticky, image loaded and checksum matched
boot_err  out  1  sticky, framing or checksum failure
words_loaded  out  16  count of words written in the current frame

Behaviour:
- Async reset: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, core_hold=1, pc_start=0, boot_done=0, boot_err=0, words_loaded=0, checksum accumulator=0, byte index=0.
- Reset mid-frame aborts the frame; memory already written is not restored.
- Frame format: MAGIC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT×4 data bytes (MSB first), then CHK.
- CHK = XOR of every byte after MAGIC, excluding CHK itself.
- rx_ready = 1 in IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, DATA, CHK; rx_ready = 0 in DONE and ERR. rx_ready is decoded from state only (no combinational path from rx_valid).
- State IDLE: a transferred byte equal to MAGIC -> ADDR_HI with accumulator cleared; any other byte is discarded and the state stays IDLE.
- States ADDR_HI / ADDR_LO / CNT_HI / CNT_LO: each transfer latches one byte and XORs it into the accumulator.
- At CNT_LO:
  - start + count > 2^ADDR_W (17-bit compare) -> ERR.
  - count == 0 -> CHK.
  - otherwise -> DATA.
- The start address is truncated to ADDR_W bits; upper bits must be zero, else -> ERR at ADDR_LO.
- State DATA: bytes shift into a 32-bit word register, MSB first.
  - On the 4th byte, the next cycle drives mem_we=1 for exactly one cycle, with mem_addr = start + words_loaded and mem_wdata = the assembled word.
  - words_loaded increments in that same cycle.
  - Bytes keep being accepted back-to-back during the write pulse; there is no stall.
  - After the last word -> CHK.
- State CHK:
  - Byte == accumulator -> DONE; pc_start = start address; core_hold drops to 0 on the cycle DONE is entered.
  - Mismatch -> ERR.
- DONE: boot_done=1, core_hold=0, rx_ready=0. Only rst leaves this state.
- ERR: boot_err=1, core_hold stays 1, rx_ready=0. Only rst leaves this state.
- Exactly one of boot_done and boot_err is ever set.
- Cycles without a transfer (rx_valid=0) hold all state; gaps of any length between bytes are legal.
- mem_we is never asserted outside DATA plus the one trailing cycle. The final word's write completes before CHK can be accepted, because CHK needs at least one further cycle.

Test Plan:
- Bytes A5 00 17 00 01 FC 00 00 00 EA, back-to-back -> one mem_we pulse with addr=23, wdata=FC000000; then boot_done=1, core_hold=0, pc_start=23, words_loaded=1.
- Same frame with CHK=EB -> the write still occurs; boot_err=1, core_hold=1, boot_done=0, rx_ready=0.
- Bytes 00 FF before A5, and rx_valid toggled every other cycle throughout the frame -> leading bytes ignored; result identical to the first scenario.
- Frame A5 00 00 00 18 followed by the 24 Fibonacci program words (28010064 … FC000000) and correct CHK -> 24 writes at addresses 0..23 in order, words_loaded=24, pc_start=0, boot_done=1.
- Frame A5 03 FF 00 02 with ADDR_W=10 (start 1023, count 2 overflows) -> boot_err=1 after CNT_LO, no mem_we.
- rst asserted after the 2nd data byte of a word, then a valid frame resent -> no write from the aborted frame; all outputs at reset values; the new frame completes with boot_done=1.

Source files
------------

// File: rtl/mips32_boot_loader.sv
// Framed byte-stream loader for the mips32 core memory.
// Holds the core halted until the image checksum matches.
module mips32_boot_loader #(
   parameter int          ADDR_W = 10,
   parameter logic [7:0]  MAGIC  = 8'hA5
) (
   input  logic              clk1,
   input  logic              rst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_hold,
   output logic [ADDR_W-1:0] pc_start,
   output logic              boot_done,
   output logic              boot_err,
   output logic [15:0]       words_loaded
);

   typedef enum logic [3:0] {
      IDLE, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO,
      DATA, CHK, DONE, ERR
   } state_t;

   state_t            state, nstate;
   logic [7:0]        acc;
   logic [7:0]        addr_hi;
   logic [7:0]        cnt_hi;
   logic [ADDR_W-1:0] start;
   logic [15:0]       cnt;
   logic [23:0]       wbuf;
   logic [1:0]        bidx;

   logic        xfer;
   logic [15:0] addr_full;
   logic [15:0] cnt_full;
   logic [16:0] end_addr;
   logic [16:0] limit;
   logic        addr_bad;
   logic        last_word;

   assign rx_ready  = (state != DONE) && (state != ERR);
   assign core_hold = (state != DONE);
   assign boot_done = (state == DONE);
   assign boot_err  = (state == ERR);

   assign xfer      = rx_valid & rx_ready;
   assign addr_full = {addr_hi, rx_data};
   assign cnt_full  = {cnt_hi, rx_data};
   assign end_addr  = {{(17-ADDR_W){1'b0}}, start}
                    + {1'b0, cnt_full};
   assign limit     = 17'd1 << ADDR_W;
   assign addr_bad  = (addr_full >> ADDR_W) != 16'd0;
   assign last_word = (words_loaded + 16'd1) == cnt;

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nstate;
   end

   always_comb begin
      nstate = state;
      if (xfer) begin
         unique case (state)
            IDLE:    if (rx_data == MAGIC) nstate = ADDR_HI;
            ADDR_HI: nstate = ADDR_LO;
            ADDR_LO: nstate = addr_bad ? ERR : CNT_HI;
            CNT_HI:  nstate = CNT_LO;
            CNT_LO: begin
               if (end_addr > limit)      nstate = ERR;
               else if (cnt_full == 16'd0) nstate = CHK;
               else                        nstate = DATA;
            end
            DATA:    if (bidx == 2'd3 && last_word) nstate = CHK;
            CHK:     nstate = (rx_data == acc) ? DONE : ERR;
            default: nstate = state;
         endcase
      end
   end

   // Write strobe is registered: fires the cycle after the 4th byte.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         acc          <= 8'd0;
         addr_hi      <= 8'd0;
         cnt_hi       <= 8'd0;
         start        <= '0;
         cnt          <= 16'd0;
         wbuf         <= 24'd0;
         bidx         <= 2'd0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= 32'd0;
         pc_start     <= '0;
         words_loaded <= 16'd0;
      end else begin
         mem_we <= 1'b0;
         if (xfer) begin
            unique case (state)
               IDLE: begin
                  if (rx_data == MAGIC) begin
                     acc          <= 8'd0;
                     bidx         <= 2'd0;
                     words_loaded <= 16'd0;
                  end
               end
               ADDR_HI: begin
                  addr_hi <= rx_data;
                  acc     <= acc ^ rx_data;
               end
               ADDR_LO: begin
                  start <= addr_full[ADDR_W-1:0];
                  acc   <= acc ^ rx_data;
               end
               CNT_HI: begin
                  cnt_hi <= rx_data;
                  acc    <= acc ^ rx_data;
               end
               CNT_LO: begin
                  cnt <= cnt_full;
                  acc <= acc ^ rx_data;
               end
               DATA: begin
                  acc  <= acc ^ rx_data;
                  wbuf <= {wbuf[15:0], rx_data};
                  bidx <= bidx + 2'd1;
                  if (bidx == 2'd3) begin
                     mem_we       <= 1'b1;
                     mem_wdata    <= {wbuf, rx_data};
                     mem_addr     <= start
                                   + words_loaded[ADDR_W-1:0];
                     words_loaded <= words_loaded + 16'd1;
                  end
               end
               CHK: if (rx_data == acc) pc_start <= start;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mips32_boot_loader.sv
// Table-driven frame bench for mips32_boot_loader.
// Expected memory writes go through a scoreboard queue.
module tb_mips32_boot_loader;

   localparam int AW = 10;

   logic          clk1 = 1'b0;
   logic          rst;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          core_hold;
   logic [AW-1:0] pc_start;
   logic          boot_done;
   logic          boot_err;
   logic [15:0]   words_loaded;

   mips32_boot_loader #(.ADDR_W(AW), .MAGIC(8'hA5)) dut (
      .clk1(clk1), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready),
      .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata),
      .core_hold(core_hold), .pc_start(pc_start),
      .boot_done(boot_done), .boot_err(boot_err),
      .words_loaded(words_loaded)
   );

   always #5 clk1 = ~clk1;

   typedef struct {
      int start;
      int count;
      bit badchk;
      bit gaps;
      bit junk;
      bit wr;
      bit exp_done;
      int exp_words;
   } vec_t;

   vec_t        vecs[8];
   logic [31:0] fib[24];
   logic [41:0] sbq[$];
   int          nvec = 0;
   int          nerr = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   always @(negedge clk1) begin
      if (!rst && mem_we) begin
         if (sbq.size() == 0) begin
            chk("unexpected_write", {22'd0, mem_addr}, 32'hFFFFFFFF);
         end else begin
            logic [41:0] e;
            e = sbq.pop_front();
            chk("wr_addr", {22'd0, mem_addr}, {22'd0, e[41:32]});
            chk("wr_data", mem_wdata, e[31:0]);
         end
      end
   end

   task automatic send(input logic [7:0] b,
                       input bit gap,
                       output bit ok);
      rx_data  = b;
      rx_valid = 1'b1;
      #1;
      ok = rx_ready;
      @(posedge clk1);
      @(negedge clk1);
      rx_valid = 1'b0;
      if (gap) @(negedge clk1);
   endtask

   task automatic do_reset();
      @(negedge clk1);
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      #1;
      chk("rst_ready", {31'd0, rx_ready}, 32'd1);
      chk("rst_hold", {31'd0, core_hold}, 32'd1);
      chk("rst_we", {31'd0, mem_we}, 32'd0);
      chk("rst_addr", {22'd0, mem_addr}, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_pc", {22'd0, pc_start}, 32'd0);
      chk("rst_done", {31'd0, boot_done}, 32'd0);
      chk("rst_err", {31'd0, boot_err}, 32'd0);
      chk("rst_words", {16'd0, words_loaded}, 32'd0);
      repeat (2) @(negedge clk1);
      rst = 1'b0;
   endtask

   task automatic run_frame(input vec_t v);
      bit          ok;
      bit          alive;
      logic [7:0]  cs;
      logic [7:0]  b;
      logic [15:0] s;
      logic [15:0] c;
      logic [31:0] w;
      logic [7:0]  hdr[4];
      s  = v.start[15:0];
      c  = v.count[15:0];
      cs = 8'h00;
      hdr[0] = s[15:8];
      hdr[1] = s[7:0];
      hdr[2] = c[15:8];
      hdr[3] = c[7:0];
      if (v.junk) begin
         send(8'h00, v.gaps, ok);
         send(8'hFF, v.gaps, ok);
      end
      send(8'hA5, v.gaps, alive);
      for (int i = 0; i < 4; i++) begin
         cs ^= hdr[i];
         if (alive) send(hdr[i], v.gaps, alive);
      end
      for (int i = 0; i < v.count; i++) begin
         w = fib[24 - v.count + i];
         for (int k = 0; k < 4; k++) begin
            b  = w[31 - 8*k -: 8];
            cs ^= b;
            if (alive) begin
               if (k == 3 && v.wr) begin
                  logic [9:0] a;
                  a = 10'(v.start + i);
                  sbq.push_back({a, w});
               end
               send(b, v.gaps, alive);
            end
         end
      end
      if (v.badchk) cs ^= 8'h01;
      if (alive) send(cs, v.gaps, ok);
      repeat (3) @(negedge clk1);
   endtask

   task automatic check_result(input vec_t v);
      chk("sb_empty", sbq.size(), 32'd0);
      chk("done", {31'd0, boot_done}, {31'd0, v.exp_done});
      chk("err", {31'd0, boot_err}, {31'd0, !v.exp_done});
      chk("hold", {31'd0, core_hold}, {31'd0, !v.exp_done});
      chk("ready", {31'd0, rx_ready}, 32'd0);
      chk("words", {16'd0, words_loaded}, v.exp_words);
      chk("pc", {22'd0, pc_start},
          v.exp_done ? 32'(v.start) : 32'd0);
      sbq.delete();
   endtask

   initial begin
      bit ok;
      logic [7:0] part[7];
      fib = '{32'h28010064, 32'h28020001, 32'h28030001,
              32'h28040002, 32'h00432820, 32'h00603020,
              32'h00A01020, 32'h00C01820, 32'h24840001,
              32'h1481FFFB, 32'hAC050040, 32'h8C070040,
              32'h00E74020, 32'h01074824, 32'h01275025,
              32'h01475826, 32'h01676027, 32'h018B682A,
              32'h2DAE0005, 32'h000D7080, 32'h000E7842,
              32'h01EE8023, 32'h0200882A, 32'hFC000000};
      //            start cnt  bad gap junk wr  done words
      vecs[0] = '{23,   1,  0,  0,  0,  1,  1,  1};
      vecs[1] = '{23,   1,  1,  0,  0,  1,  0,  1};
      vecs[2] = '{23,   1,  0,  1,  1,  1,  1,  1};
      vecs[3] = '{0,    24, 0,  0,  0,  1,  1,  24};
      vecs[4] = '{1023, 2,  0,  0,  0,  0,  0,  0};
      vecs[5] = '{1024, 1,  0,  0,  0,  0,  0,  0};
      vecs[6] = '{1000, 0,  0,  0,  0,  0,  1,  0};
      vecs[7] = '{1022, 2,  0,  1,  0,  1,  1,  2};
      rst      = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      for (int i = 0; i < 8; i++) begin
         do_reset();
         run_frame(vecs[i]);
         check_result(vecs[i]);
      end
      // Abort a frame after two data bytes of its first word.
      do_reset();
      part = '{8'hA5, 8'h00, 8'h17, 8'h00,
               8'h01, 8'hFC, 8'h00};
      for (int i = 0; i < 7; i++) send(part[i], 1'b0, ok);
      chk("abort_words", {16'd0, words_loaded}, 32'd0);
      do_reset();
      repeat (3) @(negedge clk1);
      chk("abort_sb", sbq.size(), 32'd0);
      run_frame(vecs[0]);
      check_result(vecs[0]);
      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
